// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_pkg
// Description : Shared definitions for the playfield-grid generator: mode
//               encoding, default 640x480 VGA timing and the coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

  // Scan-coordinate width; covers 0..1023, enough for an 800x525 raster.
  localparam int unsigned COORD_W = 10;

  // Default 640x480 @ 60 Hz raster, blanking included.
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_TOTAL  = 525;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  // Layer-enable modes, each one a superset of the previous.
  typedef enum logic [1:0] {
    GRID_OFF   = 2'b00,
    GRID_H     = 2'b01,
    GRID_HV    = 2'b10,
    GRID_HV_HL = 2'b11
  } grid_mode_e;

  // Last pixel covered by the final line of an axis.
  function automatic int unsigned line_span_end(
    input int unsigned first,
    input int unsigned pitch,
    input int unsigned thick,
    input int unsigned n
  );
    return first + (n - 1) * pitch + thick - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_axis_tracker.sv
`default_nettype none
// ============================================================================
// Module      : grid_axis_tracker
// Description : Incremental line tracker for one scan axis. Keeps a phase
//               counter (mod PITCH) and a line index that follow the scan
//               coordinate, so line membership needs no per-line comparators.
//               All outputs describe the coordinate presented on coord_i,
//               i.e. the value the owning scan counter is about to load.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i          in   system clock
//   rst_ni         in   asynchronous reset, active-low
//   step_i         in   the axis coordinate advances to coord_i this cycle
//   restart_i      in   coord_i is the wrap back to 0
//   coord_i        in   next coordinate value
//   on_o           out  coord_i lies on one of the N lines
//   idx_o          out  line index (saturates at N past the last line)
//   inside_cell_o  out  coord_i lies strictly between line idx_o and idx_o+1
// ============================================================================
module grid_axis_tracker #(
  parameter int unsigned W     = 10,
  parameter int unsigned FIRST = 9,
  parameter int unsigned PITCH = 50,
  parameter int unsigned THICK = 9,
  parameter int unsigned N     = 13,
  parameter int unsigned IDX_W = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             restart_i,
  input  logic [W-1:0]     coord_i,
  output logic             on_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             inside_cell_o
);

  localparam int unsigned PH_W = (PITCH > 1) ? $clog2(PITCH) : 1;

  localparam logic [W-1:0]     FIRST_C    = W'(FIRST);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PITCH - 1);
  localparam logic [PH_W-1:0]  PH_THICK   = PH_W'(THICK);
  localparam logic [IDX_W-1:0] IDX_N      = IDX_W'(N);
  localparam logic [IDX_W-1:0] IDX_LAST_C = IDX_W'(N - 1);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             started_q, started_d;  // coordinate has reached FIRST

  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    started_d = started_q;
    if (step_i) begin
      // FIRST is checked before the wrap so FIRST==0 still starts line 0.
      if (coord_i == FIRST_C) begin
        started_d = 1'b1;
        phase_d   = '0;
        idx_d     = '0;
      end else if (restart_i) begin
        started_d = 1'b0;
        phase_d   = '0;
        idx_d     = '0;
      end else if (started_q) begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          // Past the last line the index parks at N instead of wrapping,
          // which keeps the tail of the raster free of phantom lines.
          if (idx_q != IDX_N) begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      started_q <= started_d;
    end
  end

  // Decoded from the next state so the owner can register the flags in the
  // same cycle it loads the matching coordinate.
  assign on_o          = started_d && (idx_d < IDX_N) && (phase_d < PH_THICK);
  assign inside_cell_o = started_d && (idx_d < IDX_LAST_C) && (phase_d >= PH_THICK);
  assign idx_o         = idx_d;

endmodule
`default_nettype wire

// File: rtl/grid_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : grid_line_gen
// Description : Playfield-grid generator for the 640x480 VGA path. Owns its
//               scan counters and produces, per pixel, horizontal-line,
//               vertical-line and blinking selected-cell flags for the colour
//               mux. Every output is registered and describes the same (x,y).
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i          in   system clock
//   rst_ni         in   asynchronous reset, active-low
//   pix_en_i       in   pixel-rate strobe; all state advances only when 1
//   mode_i         in   00 off, 01 H lines, 10 H+V lines, 11 H+V+highlight
//   sel_row_i      in   selected cell row (latched at frame start)
//   sel_col_i      in   selected cell column (latched at frame start)
//   x_o / y_o      out  current pixel column / row
//   frame_start_o  out  set on the pixel update entering (0,0)
//   h_line_o       out  pixel is on a horizontal line
//   v_line_o       out  pixel is on a vertical line
//   highlight_o    out  pixel is inside the selected cell and blink is on
// ============================================================================
module grid_line_gen
  import grid_pkg::*;
#(
  parameter int unsigned H_TOTAL   = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL   = VGA_V_TOTAL,
  parameter int unsigned X_LO      = 9,
  parameter int unsigned X_HI      = 630,
  parameter int unsigned Y_FIRST   = 78,
  parameter int unsigned X_FIRST   = 9,
  parameter int unsigned PITCH     = 50,
  parameter int unsigned THICK     = 9,
  parameter int unsigned N_HLINES  = 7,
  parameter int unsigned N_VLINES  = 13,
  parameter int unsigned BLINK_FRM = 30
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_en_i,
  input  logic [1:0]         mode_i,
  input  logic [3:0]         sel_row_i,
  input  logic [3:0]         sel_col_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               frame_start_o,
  output logic               h_line_o,
  output logic               v_line_o,
  output logic               highlight_o
);

  localparam int unsigned Y_LAST   = line_span_end(Y_FIRST, PITCH, THICK, N_HLINES);
  localparam int unsigned X_LAST_V = line_span_end(X_FIRST, PITCH, THICK, N_VLINES);
  localparam int unsigned XI_W     = $clog2(N_VLINES + 1);
  localparam int unsigned YI_W     = $clog2(N_HLINES + 1);
  localparam int unsigned BK_W     = $clog2(BLINK_FRM + 1);
  localparam int unsigned CMP_W    = 16;

  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_LO_C    = COORD_W'(X_LO);
  localparam logic [COORD_W-1:0] X_HI_C    = COORD_W'(X_HI);
  localparam logic [COORD_W-1:0] Y_FIRST_C = COORD_W'(Y_FIRST);
  localparam logic [COORD_W-1:0] Y_LAST_C  = COORD_W'(Y_LAST);
  localparam logic [BK_W-1:0]    BK_LAST   = BK_W'(BLINK_FRM - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time geometry checks
  // --------------------------------------------------------------------------
  if (Y_LAST >= VGA_V_ACTIVE) begin : g_chk_ylast
    $error("grid_line_gen: last horizontal line ends outside the visible area");
  end
  if (X_LAST_V >= VGA_H_ACTIVE) begin : g_chk_xlast
    $error("grid_line_gen: last vertical line ends outside the visible area");
  end
  if (THICK >= PITCH) begin : g_chk_thick
    $error("grid_line_gen: THICK must be smaller than PITCH");
  end
  if ((N_HLINES < 2) || (N_VLINES < 2)) begin : g_chk_count
    $error("grid_line_gen: at least two lines are needed on each axis");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               x_wrap, y_wrap;

  logic [3:0]         sel_row_q, sel_row_d;
  logic [3:0]         sel_col_q, sel_col_d;
  logic [BK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  logic               frame_start_q, frame_start_d;
  logic               h_line_q, h_line_d;
  logic               v_line_q, v_line_d;
  logic               highlight_q, highlight_d;

  logic               x_on, x_inside;
  logic [XI_W-1:0]    x_idx;
  logic               y_on, y_inside;
  logic [YI_W-1:0]    y_idx;

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  always_comb begin
    x_wrap = (x_q == X_MAX);
    y_wrap = (y_q == Y_MAX);
    x_d    = x_wrap ? '0 : x_q + 1'b1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Axis trackers: x follows every pixel, y steps once per line.
  // Vertical lines are positioned along x, horizontal lines along y.
  // --------------------------------------------------------------------------
  grid_axis_tracker #(
    .W     (COORD_W),
    .FIRST (X_FIRST),
    .PITCH (PITCH),
    .THICK (THICK),
    .N     (N_VLINES),
    .IDX_W (XI_W)
  ) u_x_axis (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .step_i        (pix_en_i),
    .restart_i     (x_wrap),
    .coord_i       (x_d),
    .on_o          (x_on),
    .idx_o         (x_idx),
    .inside_cell_o (x_inside)
  );

  grid_axis_tracker #(
    .W     (COORD_W),
    .FIRST (Y_FIRST),
    .PITCH (PITCH),
    .THICK (THICK),
    .N     (N_HLINES),
    .IDX_W (YI_W)
  ) u_y_axis (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .step_i        (pix_en_i & x_wrap),
    .restart_i     (y_wrap),
    .coord_i       (y_d),
    .on_o          (y_on),
    .idx_o         (y_idx),
    .inside_cell_o (y_inside)
  );

  // --------------------------------------------------------------------------
  // Frame-rate state and flag decode for the pixel being loaded
  // --------------------------------------------------------------------------
  always_comb begin
    frame_start_d = (x_d == '0) && (y_d == '0);

    // The selection only moves at a frame boundary so a cell never tears.
    sel_row_d = frame_start_d ? sel_row_i : sel_row_q;
    sel_col_d = frame_start_d ? sel_col_i : sel_col_q;

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start_d) begin
      if (blink_cnt_q == BK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    h_line_d = y_on && (x_d >= X_LO_C) && (x_d <= X_HI_C) &&
               (mode_i != GRID_OFF);
    v_line_d = x_on && (y_d >= Y_FIRST_C) && (y_d <= Y_LAST_C) && mode_i[1];

    // inside_cell is only true for indices below N-1, so an out-of-range
    // selection can never match.
    highlight_d = (mode_i == GRID_HV_HL) && blink_on_d &&
                  x_inside && y_inside &&
                  (CMP_W'(x_idx) == CMP_W'(sel_col_d)) &&
                  (CMP_W'(y_idx) == CMP_W'(sel_row_d));
  end

  // frame_start is held with everything else while pix_en_i is low, so the
  // output set stays coherent for downstream logic sampling on any cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q           <= '0;
      y_q           <= '0;
      sel_row_q     <= '0;
      sel_col_q     <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      h_line_q      <= 1'b0;
      v_line_q      <= 1'b0;
      highlight_q   <= 1'b0;
    end else if (pix_en_i) begin
      x_q           <= x_d;
      y_q           <= y_d;
      sel_row_q     <= sel_row_d;
      sel_col_q     <= sel_col_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      frame_start_q <= frame_start_d;
      h_line_q      <= h_line_d;
      v_line_q      <= v_line_d;
      highlight_q   <= highlight_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = frame_start_q;
  assign h_line_o      = h_line_q;
  assign v_line_o      = v_line_q;
  assign highlight_o   = highlight_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_line_gen
// Description : Self-checking bench for grid_line_gen on a reduced raster
//               (32x24, pitch 6, thickness 2, 3x4 lines, 2-frame blink) so
//               multi-frame behaviour fits in a few thousand cycles.
//               Geometry of this instance:
//                 H lines at y 3-4, 9-10, 15-16 spanning x 2..28
//                 V lines at x 2-3, 8-9, 14-15, 20-21 spanning y 3..16
//                 cell columns x 4-7, 10-13, 16-19; cell rows y 5-8, 11-14
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_line_gen;

  localparam int H_TOTAL   = 32;
  localparam int V_TOTAL   = 24;
  localparam int X_LO      = 2;
  localparam int X_HI      = 28;
  localparam int Y_FIRST   = 3;
  localparam int X_FIRST   = 2;
  localparam int PITCH     = 6;
  localparam int THICK     = 2;
  localparam int N_HLINES  = 3;
  localparam int N_VLINES  = 4;
  localparam int BLINK_FRM = 2;
  localparam int FRAME     = H_TOTAL * V_TOTAL;

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       pix_en_i  = 1'b0;
  logic [1:0] mode_i    = 2'b00;
  logic [3:0] sel_row_i = 4'd0;
  logic [3:0] sel_col_i = 4'd0;
  logic [9:0] x_o, y_o;
  logic       frame_start_o, h_line_o, v_line_o, highlight_o;

  int n_checks = 0;
  int n_pass   = 0;
  int bx = 0;
  int by = 0;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] mode;
    logic [2:0] exp;   // {h_line, v_line, highlight}
  } vec_t;

  vec_t tbl[23];

  grid_line_gen #(
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .X_LO      (X_LO),
    .X_HI      (X_HI),
    .Y_FIRST   (Y_FIRST),
    .X_FIRST   (X_FIRST),
    .PITCH     (PITCH),
    .THICK     (THICK),
    .N_HLINES  (N_HLINES),
    .N_VLINES  (N_VLINES),
    .BLINK_FRM (BLINK_FRM)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pix_en_i      (pix_en_i),
    .mode_i        (mode_i),
    .sel_row_i     (sel_row_i),
    .sel_col_i     (sel_col_i),
    .x_o           (x_o),
    .y_o           (y_o),
    .frame_start_o (frame_start_o),
    .h_line_o      (h_line_o),
    .v_line_o      (v_line_o),
    .highlight_o   (highlight_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // {x, y, frame_start, h_line, v_line, highlight}
  function automatic logic [31:0] snap();
    return 32'({x_o, y_o, frame_start_o, h_line_o, v_line_o, highlight_o});
  endfunction

  function automatic logic [31:0] want(input int x, input int y, input logic [3:0] f);
    return 32'({10'(x), 10'(y), f});
  endfunction

  // One pixel advance; bench keeps its own raster position.
  task automatic step();
    pix_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (bx == H_TOTAL - 1) begin
      bx = 0;
      by = (by == V_TOTAL - 1) ? 0 : by + 1;
    end else begin
      bx++;
    end
  endtask

  task automatic goto(input int tx, input int ty);
    int n = 0;
    while (!(bx == tx && by == ty)) begin
      step();
      n++;
      if (n > 2 * FRAME) begin
        $display("FAIL goto: position (%0d,%0d) not reached", tx, ty);
        $fatal(1, "goto bound expired");
      end
    end
  endtask

  int  hc, vc, lc, fsc;
  bit  frozen_ok;

  initial begin
    // Frame 0 raster walk; latched selection is (0,0), blink on.
    tbl[0]  = '{1,  3,  2'b01, 3'b000};
    tbl[1]  = '{2,  3,  2'b01, 3'b100};
    tbl[2]  = '{8,  3,  2'b10, 3'b110};
    tbl[3]  = '{5,  4,  2'b11, 3'b100};
    tbl[4]  = '{28, 4,  2'b10, 3'b100};
    tbl[5]  = '{29, 4,  2'b10, 3'b000};
    tbl[6]  = '{2,  5,  2'b11, 3'b010};
    tbl[7]  = '{4,  5,  2'b11, 3'b001};
    tbl[8]  = '{7,  8,  2'b11, 3'b001};
    tbl[9]  = '{8,  8,  2'b11, 3'b010};
    tbl[10] = '{4,  9,  2'b11, 3'b100};
    tbl[11] = '{10, 11, 2'b11, 3'b000};
    tbl[12] = '{17, 12, 2'b11, 3'b000};
    tbl[13] = '{20, 12, 2'b10, 3'b010};
    tbl[14] = '{22, 12, 2'b10, 3'b000};
    tbl[15] = '{26, 12, 2'b10, 3'b000};
    tbl[16] = '{8,  15, 2'b00, 3'b000};
    tbl[17] = '{9,  15, 2'b01, 3'b100};
    tbl[18] = '{3,  16, 2'b11, 3'b110};
    tbl[19] = '{8,  16, 2'b10, 3'b110};
    tbl[20] = '{21, 16, 2'b10, 3'b110};
    tbl[21] = '{8,  17, 2'b10, 3'b000};
    tbl[22] = '{2,  21, 2'b11, 3'b000};

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", snap(), want(0, 0, 4'b0000));
    rst_ni = 1'b1;

    // Mid-frame request for cell (1,2); must not apply until frame 1.
    sel_row_i = 4'd1;
    sel_col_i = 4'd2;

    for (int i = 0; i < 23; i++) begin
      mode_i = tbl[i].mode;
      goto(tbl[i].x, tbl[i].y);
      check($sformatf("vec%0d_x%0d_y%0d", i, tbl[i].x, tbl[i].y),
            snap(), want(tbl[i].x, tbl[i].y, {1'b0, tbl[i].exp}));
    end

    // Frame boundary pulse.
    goto(H_TOTAL - 1, V_TOTAL - 1);
    step();
    check("frame_start_pulse", 32'({x_o, y_o, frame_start_o}), 32'({10'd0, 10'd0, 1'b1}));
    step();
    check("frame_start_drop", 32'(frame_start_o), 32'd0);

    // Frame 1: selection (1,2) now latched; change it mid-frame.
    mode_i = 2'b11;
    goto(16, 11);
    check("sel_new_frame", snap(), want(16, 11, 4'b0001));
    sel_row_i = 4'd0;
    sel_col_i = 4'd0;
    goto(19, 14);
    check("sel_midframe_hold", snap(), want(19, 14, 4'b0001));

    // Frames 2 and 3: blink off; frame 4: blink on again.
    goto(0, 0);
    goto(4, 5);
    check("blink_off_f2", snap(), want(4, 5, 4'b0000));
    goto(0, 0);
    goto(7, 8);
    check("blink_off_f3", snap(), want(7, 8, 4'b0000));
    goto(0, 0);
    goto(4, 5);
    check("blink_on_f4", snap(), want(4, 5, 4'b0001));

    // Strobe held low: everything freezes, then resumes at the next column.
    goto(5, 9);
    check("pre_freeze", snap(), want(5, 9, 4'b0100));
    pix_en_i  = 1'b0;
    frozen_ok = 1'b1;
    repeat (20) begin
      @(posedge clk_i);
      #1;
      if (snap() !== want(5, 9, 4'b0100)) frozen_ok = 1'b0;
    end
    check("freeze_hold", 32'(frozen_ok), 32'd1);
    step();
    check("resume", snap(), want(6, 9, 4'b0100));

    // Frame 5 full scan with an out-of-range row selection.
    sel_row_i = 4'd2;
    sel_col_i = 4'd0;
    goto(0, 0);
    hc = 0; vc = 0; lc = 0; fsc = 0;
    for (int i = 0; i < FRAME; i++) begin
      hc  += int'(h_line_o);
      vc  += int'(v_line_o);
      lc  += int'(highlight_o);
      fsc += int'(frame_start_o);
      if (i != FRAME - 1) step();
    end
    check("frame_hline_count", 32'(hc), 32'd162);
    check("frame_vline_count", 32'(vc), 32'd112);
    check("frame_oob_sel_highlight", 32'(lc), 32'd0);
    check("frame_start_count", 32'(fsc), 32'd1);

    // Frame 6 (blink off): asynchronous reset mid-frame.
    step();
    sel_row_i = 4'd1;
    sel_col_i = 4'd1;
    goto(10, 10);
    #3;
    rst_ni = 1'b0;
    #1;
    check("async_reset_now", snap(), want(0, 0, 4'b0000));
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("async_reset_hold", snap(), want(0, 0, 4'b0000));
    rst_ni = 1'b1;
    bx = 0;
    by = 0;

    // After reset: blink on and latched selection back at (0,0).
    mode_i = 2'b11;
    goto(4, 5);
    check("post_reset_sel0_blink", snap(), want(4, 5, 4'b0001));
    goto(10, 11);
    check("post_reset_unlatched", snap(), want(10, 11, 4'b0000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
